// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the N-way intersection controller.
//   tl_state_t : per-intersection phase (green, yellow, all-red clearance)
//   idx_w(n)   : width of an index that addresses n approaches (min 1 bit)
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } tl_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_ctrl_nway_rr_next.sv
// ---------------------------------------------------------------------------
// rr_next
// Combinational round-robin finder. Scans req starting at index 'start' and
// walks upward with wrap-around; reports the first set bit.
//   req   : request vector, one bit per approach
//   start : first index examined
//   found : at least one request bit is set
//   idx   : index of the first set request (equals start when none found)
// ---------------------------------------------------------------------------
module rr_next
    import traffic_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // The first hit wins; later candidates are ignored once found is set.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(start) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// ---------------------------------------------------------------------------
// traffic_ctrl_nway
// Round-robin N-way intersection signal controller with latched sensor
// requests, demand-actuated green (min/max), fixed yellow and all-red.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   sense   : vehicle present per approach (already synchronous to clk)
//   green   : green lamp per approach (registered)
//   yellow  : yellow lamp per approach (registered)
//   red     : red lamp per approach (registered)
//   active  : index of the approach currently served (registered)
// ---------------------------------------------------------------------------
module traffic_ctrl_nway
    import traffic_pkg::*;
#(
    parameter int N_WAYS    = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_WAYS-1:0]         sense,
    output logic [N_WAYS-1:0]         green,
    output logic [N_WAYS-1:0]         yellow,
    output logic [N_WAYS-1:0]         red,
    output logic [$clog2(N_WAYS)-1:0] active
);

    localparam int AW = idx_w(N_WAYS);

    // Timer must hold the largest terminal count of any phase.
    localparam int TMR_MAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX - 1 : YELLOW_T - 1;
    localparam int TMR_MAX   = (TMR_MAX_A > ALLRED_T - 1) ? TMR_MAX_A : ALLRED_T - 1;
    localparam int TMR_W     = $clog2(TMR_MAX + 2);

    localparam logic [TMR_W-1:0] G_MIN_L = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] G_MAX_L = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] Y_L     = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] A_L     = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    localparam logic [N_WAYS-1:0] ONE_HOT0 = N_WAYS'(1);

    tl_state_t           state, state_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [AW-1:0]       active_n;
    logic [N_WAYS-1:0]   req, req_n;
    logic [N_WAYS-1:0]   green_n, yellow_n, red_n;

    logic [N_WAYS-1:0]   act_mask;
    logic [N_WAYS-1:0]   next_mask;
    logic                other;
    logic                enter_green;
    logic [AW-1:0]       rr_start;
    logic                rr_found;
    logic [AW-1:0]       rr_idx;

    assign act_mask = ONE_HOT0 << active;
    assign other    = |(req & ~act_mask);
    assign rr_start = AW'((int'(active) + 1) % N_WAYS);

    rr_next #(
        .N (N_WAYS),
        .W (AW)
    ) u_rr_next (
        .req   (req),
        .start (rr_start),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Phase sequencing. Green holds for at least GREEN_MIN cycles, then yields
    // to competing demand when its own sensor is clear or the max is hit.
    // Without competing demand green rests and the timer parks at the max.
    always_comb begin
        state_n     = state;
        tmr_n       = tmr;
        active_n    = active;
        enter_green = 1'b0;
        case (state)
            S_GREEN: begin
                if (tmr < G_MIN_L) begin
                    tmr_n = tmr + TMR_ONE;
                end else if (other && (!sense[active] || tmr == G_MAX_L)) begin
                    state_n = S_YELLOW;
                    tmr_n   = '0;
                end else if (tmr != G_MAX_L) begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            S_YELLOW: begin
                if (tmr == Y_L) begin
                    state_n = S_ALLRED;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            S_ALLRED: begin
                if (tmr == A_L) begin
                    state_n     = S_GREEN;
                    tmr_n       = '0;
                    enter_green = 1'b1;
                    if (rr_found) begin
                        active_n = rr_idx;
                    end
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            default: begin
                state_n = S_GREEN;
                tmr_n   = '0;
            end
        endcase
    end

    // Request latches: a sensor only registers demand while its approach is
    // not showing green. The clear on green entry overrides a same-cycle set.
    // Lamps are decoded from the next state so they change on the same edge
    // that commits the phase change.
    always_comb begin
        next_mask = ONE_HOT0 << active_n;
        req_n     = (req | (sense & ~((state == S_GREEN) ? act_mask : '0)))
                    & ~(enter_green ? next_mask : '0);
        green_n   = (state_n == S_GREEN)  ? next_mask : '0;
        yellow_n  = (state_n == S_YELLOW) ? next_mask : '0;
        red_n     = ~(green_n | yellow_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_GREEN;
            tmr    <= '0;
            active <= '0;
            req    <= '0;
            green  <= ONE_HOT0;
            yellow <= '0;
            red    <= ~ONE_HOT0;
        end else begin
            state  <= state_n;
            tmr    <= tmr_n;
            active <= active_n;
            req    <= req_n;
            green  <= green_n;
            yellow <= yellow_n;
            red    <= red_n;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// ---------------------------------------------------------------------------
// tb_traffic_ctrl_nway
// Directed bench for traffic_ctrl_nway with N_WAYS=4, GREEN_MIN=4,
// GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1. Cycle k means the values visible
// after k rising edges following reset release; sampling is on the falling
// edge and sense is driven there too.
// ---------------------------------------------------------------------------
module tb_traffic_ctrl_nway;

    logic       clk;
    logic       reset_n;
    logic [3:0] sense;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] active;

    int compareCount = 0;
    int failCount    = 0;

    traffic_ctrl_nway #(
        .N_WAYS    (4),
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .ALLRED_T  (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sense   (sense),
        .green   (green),
        .yellow  (yellow),
        .red     (red),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        sense = value;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called from a falling-edge sample point; the 2 ns low pulse lies
    // entirely between clock edges, so reset values must appear without one.
    task automatic pulseReset(input string tag);
        #1 reset_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_green"},  green,  32'h1);
        checkOutput({tag, "_rst_yellow"}, yellow, 32'h0);
        checkOutput({tag, "_rst_red"},    red,    32'hE);
        checkOutput({tag, "_rst_active"}, active, 32'h0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int holdErrs;
        int lampErrs;
        int nonRedErrs;

        reset_n = 1'b0;
        sense   = 4'b0000;
        @(negedge clk);

        // Test 1: reset, no demand, way 0 rests in green.
        $display("[TB] test 1: reset and idle rest");
        applyStimulus(4'b0000);
        pulseReset("t1");
        holdErrs = 0;
        for (int c = 1; c <= 50; c++) begin
            stepCycle();
            if (green !== 4'b0001 || red !== 4'b1110) holdErrs++;
        end
        checkOutput("t1_hold_errs", holdErrs, 0);
        checkOutput("t1_active_c50", active, 0);

        // Test 2: demand on way 2 only.
        $display("[TB] test 2: single competing demand");
        pulseReset("t2");
        applyStimulus(4'b0100);
        for (int c = 1; c <= 7; c++) begin
            stepCycle();
            case (c)
                3: checkOutput("t2_green_c3", green, 4'b0001);
                4: begin
                    checkOutput("t2_green_c4",  green,  4'b0000);
                    checkOutput("t2_yellow_c4", yellow, 4'b0001);
                end
                5: checkOutput("t2_yellow_c5", yellow, 4'b0001);
                6: checkOutput("t2_red_c6", red, 4'b1111);
                7: begin
                    checkOutput("t2_green_c7",  green,  4'b0100);
                    checkOutput("t2_active_c7", active, 2);
                end
                default: ;
            endcase
        end

        // Test 3: own sensor held, competing demand on way 3: max green.
        $display("[TB] test 3: max green");
        pulseReset("t3");
        applyStimulus(4'b1001);
        for (int c = 1; c <= 13; c++) begin
            stepCycle();
            case (c)
                9:  checkOutput("t3_green_c9", green, 4'b0001);
                10: checkOutput("t3_yellow_c10", yellow, 4'b0001);
                12: checkOutput("t3_red_c12", red, 4'b1111);
                13: begin
                    checkOutput("t3_green_c13",  green,  4'b1000);
                    checkOutput("t3_active_c13", active, 3);
                end
                default: ;
            endcase
        end

        // Test 4: all ways request continuously; 13-cycle rotation.
        $display("[TB] test 4: full demand rotation");
        pulseReset("t4");
        applyStimulus(4'b1111);
        lampErrs   = 0;
        nonRedErrs = 0;
        for (int c = 1; c <= 52; c++) begin
            stepCycle();
            if ((green | yellow | red) !== 4'b1111 || (green & yellow) !== 4'b0000 ||
                (green & red) !== 4'b0000 || (yellow & red) !== 4'b0000) lampErrs++;
            if ($countones(~red) > 1) nonRedErrs++;
            case (c)
                9:  checkOutput("t4_green_c9", green, 4'b0001);
                10: checkOutput("t4_yellow_c10", yellow, 4'b0001);
                13: checkOutput("t4_active_c13", active, 1);
                22: checkOutput("t4_green_c22", green, 4'b0010);
                23: checkOutput("t4_yellow_c23", yellow, 4'b0010);
                26: checkOutput("t4_active_c26", active, 2);
                39: checkOutput("t4_active_c39", active, 3);
                52: begin
                    checkOutput("t4_active_c52", active, 0);
                    checkOutput("t4_green_c52",  green,  4'b0001);
                end
                default: ;
            endcase
        end
        checkOutput("t4_lamp_errs",   lampErrs,   0);
        checkOutput("t4_nonred_errs", nonRedErrs, 0);

        // Test 5: way 2 pulses during way 0's yellow; it beats way 3.
        $display("[TB] test 5: request latched during yellow");
        pulseReset("t5");
        applyStimulus(4'b1000);
        for (int c = 1; c <= 14; c++) begin
            stepCycle();
            case (c)
                1: applyStimulus(4'b0000);
                4: begin
                    checkOutput("t5_yellow_c4", yellow, 4'b0001);
                    applyStimulus(4'b0100);
                end
                5: applyStimulus(4'b0000);
                7: begin
                    checkOutput("t5_green_c7",  green,  4'b0100);
                    checkOutput("t5_active_c7", active, 2);
                end
                14: begin
                    checkOutput("t5_green_c14",  green,  4'b1000);
                    checkOutput("t5_active_c14", active, 3);
                end
                default: ;
            endcase
        end

        // Test 6: reset during way 1's yellow discards way 3's pending request.
        $display("[TB] test 6: reset during yellow");
        pulseReset("t6a");
        applyStimulus(4'b0010);
        for (int c = 1; c <= 11; c++) begin
            stepCycle();
            case (c)
                1: applyStimulus(4'b0000);
                7: begin
                    checkOutput("t6_active_c7", active, 1);
                    applyStimulus(4'b1000);
                end
                8: applyStimulus(4'b0000);
                11: checkOutput("t6_yellow_c11", yellow, 4'b0010);
                default: ;
            endcase
        end
        pulseReset("t6b");
        holdErrs = 0;
        for (int c = 1; c <= 35; c++) begin
            stepCycle();
            if (c <= 30 && green !== 4'b0001) holdErrs++;
            case (c)
                30: applyStimulus(4'b1000);
                31: applyStimulus(4'b0000);
                32: checkOutput("t6_yellow_c32", yellow, 4'b0001);
                35: begin
                    checkOutput("t6_green_c35",  green,  4'b1000);
                    checkOutput("t6_active_c35", active, 3);
                end
                default: ;
            endcase
        end
        checkOutput("t6_hold_errs", holdErrs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_nway.md
# traffic_ctrl_nway

Parametrised N-way intersection signal controller: the successor to the two-street sensor controller. It serves up to `N_WAYS` approaches in round-robin order. Sensor requests are latched. Green time is demand-actuated, with a minimum and a maximum. Fixed yellow and all-red clearance intervals follow each green. It drives one Green/Yellow/Red lamp triple per approach and sits directly behind the sensor synchronisers in the intersection top level.

## Interface
Parameters:
- `N_WAYS`, 4: number of approaches, 2..8.
- `GREEN_MIN`, 4: minimum green cycles, ≥1.
- `GREEN_MAX`, 10: maximum green cycles under competing demand, ≥ `GREEN_MIN`.
- `YELLOW_T`, 2: yellow cycles, ≥1.
- `ALLRED_T`, 1: all-red clearance cycles, ≥1.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `sense`, in, `N_WAYS`: vehicle present per approach, already synchronous to `clk`.
- `green`, out, `N_WAYS`: green lamp per approach.
- `yellow`, out, `N_WAYS`: yellow lamp per approach.
- `red`, out, `N_WAYS`: red lamp per approach.
- `active`, out, `$clog2(N_WAYS)`: index of the approach currently served.

## Operation
- State machine states are `S_GREEN`, `S_YELLOW` and `S_ALLRED`.
- `tmr` counts cycles spent in the current state. It clears on every state change.
- Request latch `req[i]`:
  - Set when `sense[i]=1` and approach `i` is not in `S_GREEN`.
  - Cleared on entry to `S_GREEN` for `i`.
  - When set and clear coincide, clear wins.
- `other` = OR of `req` excluding `active`.
- `S_GREEN` rules, evaluated in this order:
  - Stay while `tmr < GREEN_MIN-1`.
  - Once `tmr ≥ GREEN_MIN-1`, go to `S_YELLOW` when `other=1` and either `sense[active]=0` or `tmr = GREEN_MAX-1`.
  - With `other=0`, rest in green indefinitely. `tmr` saturates at `GREEN_MAX-1`.
- `S_YELLOW` → `S_ALLRED` when `tmr = YELLOW_T-1`.
- `S_ALLRED` → `S_GREEN` when `tmr = ALLRED_T-1`:
  - `active` becomes the first approach with `req` set, searching upward from `active+1` with wrap-around.
  - If no request exists, `active` is kept unchanged.
- Lamp outputs:
  - Approach `active`: green in `S_GREEN`, yellow in `S_YELLOW`, red in `S_ALLRED`.
  - Every other approach: red.
  - Exactly one lamp per approach is lit. At most one approach is non-red.
- Reset values:
  - State `S_GREEN`, `active=0`, `tmr=0`, `req=0`.
  - `green=1`, i.e. bit 0 set and all other bits clear.
  - `yellow=0`.
  - `red` = all ones except bit 0.
- Reset asserted mid-cycle forces these values immediately, independent of `clk`.

## Timing
- All outputs are registered. Lamps change on the clock edge that commits the state change. There is no combinational path from `sense` to outputs.
- `sense` affects `req` one edge later. That `req` can trigger a transition on the following edge.
- Green duration:
  - Minimum `GREEN_MIN` cycles.
  - Maximum `GREEN_MAX` cycles while other demand exists.
  - Unbounded with no other demand.
- Yellow lasts exactly `YELLOW_T` cycles. All-red lasts exactly `ALLRED_T` cycles.
- Boundary cases:
  - If `sense[active]` drops in the same cycle that `tmr` reaches `GREEN_MIN-1` and `other=1`, yellow starts on the next edge.
  - A request that arrives during yellow or all-red is eligible for the upcoming green.
  - If all ways request simultaneously, service order is strictly `active+1`, `active+2`, and so on, modulo `N_WAYS`.

## Structure
- Package `traffic_pkg`:
  - State enum `tl_state_t` {`S_GREEN`, `S_YELLOW`, `S_ALLRED`}.
  - Function `idx_w(n)` returning the `$clog2` index width.
- Sub-module `rr_next`:
  - Combinational round-robin finder.
  - Inputs: `req` and `start`.
  - Outputs: `found` and `idx`.
- The FSM, timer, request latches and output decode live in the top level.

## Test plan
All scenarios use `N_WAYS=4`, `GREEN_MIN=4`, `GREEN_MAX=10`, `YELLOW_T=2`, `ALLRED_T=1`.

1. Pulse `reset_n` low for 2 ns mid-cycle, `sense=0` → immediately `green=0001`, `red=1110`, `active=0`; approach 0 stays green for 50 cycles with no demand.
2. `sense=0100` held from cycle 0 → way 0 green for 4 cycles, then yellow for 2, all-red for 1; on cycle 7 `active=2`, `green=0100`.
3. `sense[0]=1` continuously with `sense=1001` → way 0 green for exactly 10 cycles, then yellow; way 3 served next.
4. `sense=1111` held → service order 0,1,2,3,0. Each green lasts 10 cycles, since its own sensor stays active. Never more than one non-red way.
5. `sense[2]` pulsed for 1 cycle during way 0's yellow → the request is latched and way 2 becomes green after all-red.
6. Assert `reset_n` low during `S_YELLOW` on way 1 → asynchronous return to way 0 green; `req` cleared; a prior pending request on way 3 is not served until `sense[3]` is reasserted.
